// File: rtl/svc_rv_wb_pkg.sv
// rtl/svc_rv_wb_pkg.sv - shared types for the write-back arbiter
package svc_rv_wb_pkg;
  localparam int WB_RD_W = 5;

  // The data word travels beside this tag, so the entry stays XLEN-independent.
  typedef struct packed {
    logic [WB_RD_W-1:0] rd;
    logic               ebreak;
  } wb_entry_t;
endpackage

// File: rtl/svc_rv_wb_fifo.sv
// rtl/svc_rv_wb_fifo.sv - single-channel circular result FIFO
module svc_rv_wb_fifo
  import svc_rv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  wb_entry_t       push_ent,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output wb_entry_t       head_ent,
  output logic [XLEN-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wptr_q, rptr_q;
  wb_entry_t       ent_q  [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty     = (wptr_q == rptr_q);
  assign head_ent  = ent_q[rptr_q[AW-1:0]];
  assign head_data = data_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        ent_q[wptr_q[AW-1:0]]  <= push_ent;
        data_q[wptr_q[AW-1:0]] <= push_data;
        wptr_q                 <= wptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/svc_rv_wb_arb.sv
// rtl/svc_rv_wb_arb.sv - round-robin write-back arbiter onto one register-file port
// Optional retire counter: define SVC_RV_WB_INSTRET_EN.
module svc_rv_wb_arb
  import svc_rv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH*WB_RD_W-1:0]  in_rd,
  input  logic [NCH*XLEN-1:0]     in_data,
  input  logic [NCH-1:0]          in_ebreak,
  output logic                    rd_we,
  output logic [WB_RD_W-1:0]      rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic                    retire,
  output logic                    ebreak,
  output logic [63:0]             instret
);
  localparam int LW = $clog2(NCH);

  logic [NCH-1:0]  full, empty, pop;
  wb_entry_t       push_ent  [NCH];
  wb_entry_t       head_ent  [NCH];
  logic [XLEN-1:0] head_data [NCH];

  logic          gnt_vld;
  logic [LW-1:0] gnt_idx, last_d, last_q;
  logic          rd_we_q, retire_q, ebreak_q;
  logic [WB_RD_W-1:0] rd_addr_q;
  logic [XLEN-1:0]    rd_data_q;

  // Held low in reset so producers never see a ready before pointers are cleared.
  assign in_ready = rst ? '0 : ~full;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign push_ent[c] = '{rd: in_rd[WB_RD_W*c +: WB_RD_W], ebreak: in_ebreak[c]};
    assign pop[c]      = gnt_vld && (gnt_idx == LW'(c));

    svc_rv_wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[c] & in_ready[c]),
      .push_ent  (push_ent[c]),
      .push_data (in_data[XLEN*c +: XLEN]),
      .pop       (pop[c]),
      .full      (full[c]),
      .empty     (empty[c]),
      .head_ent  (head_ent[c]),
      .head_data (head_data[c])
    );
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    for (int i = 1; i <= NCH; i++) begin
      if (!gnt_vld && !empty[(int'(last_q) + i) % NCH]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'((int'(last_q) + i) % NCH);
      end
    end
    last_d = gnt_vld ? gnt_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= LW'(NCH - 1);
      retire_q  <= 1'b0;
      rd_we_q   <= 1'b0;
      ebreak_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      last_q   <= last_d;
      retire_q <= gnt_vld;
      rd_we_q  <= gnt_vld && (head_ent[gnt_idx].rd != '0);
      ebreak_q <= gnt_vld && head_ent[gnt_idx].ebreak;
      if (gnt_vld) begin
        rd_addr_q <= head_ent[gnt_idx].rd;
        rd_data_q <= head_data[gnt_idx];
      end
    end
  end

  assign rd_we   = rd_we_q;
  assign retire  = retire_q;
  assign ebreak  = ebreak_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;

`ifdef SVC_RV_WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (gnt_vld) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule
